// File: rtl/battle_phase_ctrl.sv
// battle_phase_ctrl
//   Game-phase sequencer for the 8x8 battleship cell memory. Walks the player
//   through placing a fixed fleet, then runs the shooting phase (hit/miss
//   marking) until every ship cell has been hit.
//
// Ports
//   clk_in       in   1  system clock, all state changes on posedge
//   rst          in   1  asynchronous reset, active-high
//   start        in   1  pulse: begin a new game (IDLE/DONE only)
//   click        in   1  pulse: left click on grid
//   rotate       in   1  pulse: toggle ship direction (PLACE only)
//   ship_placed  in   1  memory ack for a placement write
//   cell_status  in   4  memory content at mouse cell (0 empty, 2 ship, 5 hit, 6 miss)
//   play_status  out  2  00 idle, 01 placing, 10 shooting, 11 game over
//   we           out  1  memory write enable, one-cycle pulse
//   new_value    out  4  value written while shooting (5 hit, 6 miss, else 0)
//   dimension    out  3  length of ship being placed (0 outside placement)
//   direction    out  1  0 = along x, 1 = along y
//   ship_idx     out  3  index of ship being placed
//   hit_count    out  5  ship cells hit so far
//   shot_count   out  8  accepted shots, saturating at 255
//   game_over    out  1  high in DONE
module battle_phase_ctrl #(
    parameter int unsigned N_SHIPS     = 4,
    // packed 3-bit ship lengths, ship 0 in [2:0]: default fleet 4,3,3,2
    parameter logic [23:0] FLEET       = 24'h0004DC,
    parameter int unsigned TOTAL_CELLS = 12
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       start,
    input  logic       click,
    input  logic       rotate,
    input  logic       ship_placed,
    input  logic [3:0] cell_status,
    output logic [1:0] play_status,
    output logic       we,
    output logic [3:0] new_value,
    output logic [2:0] dimension,
    output logic       direction,
    output logic [2:0] ship_idx,
    output logic [4:0] hit_count,
    output logic [7:0] shot_count,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        PLACE,
        PLACE_WR,
        SHOOT,
        SHOOT_WR,
        DONE
    } state_t;

    localparam logic [3:0] CELL_EMPTY = 4'd0;
    localparam logic [3:0] CELL_SHIP  = 4'd2;
    localparam logic [3:0] CELL_HIT   = 4'd5;
    localparam logic [3:0] CELL_MISS  = 4'd6;
    localparam logic [2:0] LAST_IDX   = 3'(N_SHIPS - 1);
    localparam logic [4:0] HIT_TARGET = 5'(TOTAL_CELLS);

    state_t     state_q, state_d;
    logic [1:0] play_q, play_d;
    logic       we_q, we_d;
    logic [3:0] nv_q, nv_d;
    logic [2:0] dim_q, dim_d;
    logic       dir_q, dir_d;
    logic [2:0] idx_q, idx_d;
    logic [4:0] hit_q, hit_d;
    logic [7:0] shot_q, shot_d;
    logic       go_q, go_d;
    logic [23:0] fleet_sh;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            play_q  <= '0;
            we_q    <= 1'b0;
            nv_q    <= '0;
            dim_q   <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            hit_q   <= '0;
            shot_q  <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            play_q  <= play_d;
            we_q    <= we_d;
            nv_q    <= nv_d;
            dim_q   <= dim_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            shot_q  <= shot_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        hit_d    = hit_q;
        shot_d   = shot_q;
        nv_d     = '0;
        fleet_sh = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PLACE;
                    idx_d   = '0;
                    dir_d   = 1'b0;
                    hit_d   = '0;
                    shot_d  = '0;
                end
            end
            PLACE: begin
                // click has priority; a simultaneous rotate is discarded
                if (click) begin
                    state_d = PLACE_WR;
                end else if (rotate) begin
                    dir_d = ~dir_q;
                end
            end
            PLACE_WR: begin
                state_d = PLACE;
                if (ship_placed) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SHOOT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            SHOOT: begin
                if (click) begin
                    if (cell_status == CELL_SHIP) begin
                        nv_d    = CELL_HIT;
                        state_d = SHOOT_WR;
                    end else if (cell_status == CELL_EMPTY) begin
                        nv_d    = CELL_MISS;
                        state_d = SHOOT_WR;
                    end
                end
            end
            SHOOT_WR: begin
                // hit is committed at the end of the write cycle, so the
                // counter moves one cycle after we
                if (shot_q != 8'hFF) begin
                    shot_d = shot_q + 8'd1;
                end
                if (nv_q == CELL_HIT) begin
                    hit_d = hit_q + 5'd1;
                end
                state_d = (hit_d == HIT_TARGET) ? DONE : SHOOT;
            end
            default: state_d = IDLE;
        endcase

        // registered outputs are decoded from the next state
        we_d = (state_d == PLACE_WR) || (state_d == SHOOT_WR);
        go_d = (state_d == DONE);
        unique case (state_d)
            PLACE, PLACE_WR: play_d = 2'b01;
            SHOOT, SHOOT_WR: play_d = 2'b10;
            DONE:            play_d = 2'b11;
            default:         play_d = 2'b00;
        endcase
        if ((state_d == PLACE) || (state_d == PLACE_WR)) begin
            fleet_sh = FLEET >> (5'(idx_d) * 5'd3);
        end
        dim_d = fleet_sh[2:0];
    end

    assign play_status = play_q;
    assign we          = we_q;
    assign new_value   = nv_q;
    assign dimension   = dim_q;
    assign direction   = dir_q;
    assign ship_idx    = idx_q;
    assign hit_count   = hit_q;
    assign shot_count  = shot_q;
    assign game_over   = go_q;

endmodule

// File: tb/tb_battle_phase_ctrl.sv
// Directed testbench for battle_phase_ctrl.
module tb_battle_phase_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       click = 1'b0;
    logic       rotate = 1'b0;
    logic       ship_placed = 1'b0;
    logic [3:0] cell_status = 4'd0;
    logic [1:0] play_status;
    logic       we;
    logic [3:0] new_value;
    logic [2:0] dimension;
    logic       direction;
    logic [2:0] ship_idx;
    logic [4:0] hit_count;
    logic [7:0] shot_count;
    logic       game_over;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // default fleet lengths, ship 0 first
    logic [2:0] len [4] = '{3'd4, 3'd3, 3'd3, 3'd2};

    battle_phase_ctrl dut (
        .clk_in(clk_in), .rst(rst), .start(start), .click(click),
        .rotate(rotate), .ship_placed(ship_placed), .cell_status(cell_status),
        .play_status(play_status), .we(we), .new_value(new_value),
        .dimension(dimension), .direction(direction), .ship_idx(ship_idx),
        .hit_count(hit_count), .shot_count(shot_count), .game_over(game_over)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // all outputs packed: play, we, nv, dim, dir, idx, hit, shot, go
    function automatic logic [27:0] outs();
        return {play_status, we, new_value, dimension, direction, ship_idx,
                hit_count, shot_count, game_over};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One placement click: checks the we cycle, then the result cycle.
    task automatic place_click(input string nm, input logic ok, input logic rot,
                               input logic hold, input logic [2:0] exp_idx,
                               input logic [1:0] exp_play, input logic exp_dir);
        logic [2:0] idx0;
        idx0 = ship_idx;
        click = 1'b1; rotate = rot; ship_placed = ok;
        tick();
        if (!hold) click = 1'b0;
        rotate = 1'b0;
        n_vec++;
        if ({we, play_status, ship_idx} !== {1'b1, 2'b01, idx0}) begin
            n_err++;
            $display("FAIL %s wr-cycle: we/play/idx=%b/%b/%0d need 1/01/%0d",
                     nm, we, play_status, ship_idx, idx0);
        end
        tick();
        click = 1'b0;
        n_vec++;
        if ({we, play_status, ship_idx, direction} !== {1'b0, exp_play, exp_idx, exp_dir}) begin
            n_err++;
            $display("FAIL %s result: we/play/idx/dir=%b/%b/%0d/%b need 0/%b/%0d/%b",
                     nm, we, play_status, ship_idx, direction, exp_play, exp_idx, exp_dir);
        end
        n_vec++;
        if (dimension !== ((exp_play == 2'b01) ? len[exp_idx] : 3'd0)) begin
            n_err++;
            $display("FAIL %s dimension: got %0d need %0d", nm, dimension,
                     (exp_play == 2'b01) ? len[exp_idx] : 3'd0);
        end
    endtask

    // One shot: checks the we cycle, then the committed counters.
    task automatic shoot(input string nm, input logic [3:0] cs, input logic exp_we,
                         input logic [3:0] exp_nv, input logic [4:0] exp_hit,
                         input logic [7:0] exp_shot, input logic [1:0] exp_play);
        logic [4:0] hit0;
        hit0 = hit_count;
        click = 1'b1; cell_status = cs;
        tick();
        click = 1'b0;
        n_vec++;
        if ({we, new_value, hit_count} !== {exp_we, exp_nv, hit0}) begin
            n_err++;
            $display("FAIL %s wr-cycle: we/nv/hit=%b/%0d/%0d need %b/%0d/%0d",
                     nm, we, new_value, hit_count, exp_we, exp_nv, hit0);
        end
        tick();
        n_vec++;
        if ({we, new_value, hit_count, shot_count, play_status, game_over} !==
            {1'b0, 4'd0, exp_hit, exp_shot, exp_play, exp_play == 2'b11}) begin
            n_err++;
            $display("FAIL %s result: we/nv/hit/shot/play/go=%b/%0d/%0d/%0d/%b/%b need 0/0/%0d/%0d/%b/%b",
                     nm, we, new_value, hit_count, shot_count, play_status, game_over,
                     exp_hit, exp_shot, exp_play, exp_play == 2'b11);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++;
        if (outs() !== 28'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h need 0000000", outs());
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (play_status !== 2'b00) begin
            n_err++;
            $display("FAIL idle_hold: play=%b need 00", play_status);
        end
    endtask

    task automatic test_place();
        pulse_start();
        n_vec++;
        if ({play_status, ship_idx, dimension, direction} !== {2'b01, 3'd0, 3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL start: play/idx/dim/dir=%b/%0d/%0d/%b need 01/0/4/0",
                     play_status, ship_idx, dimension, direction);
        end
        place_click("ship0", 1'b1, 1'b0, 1'b0, 3'd1, 2'b01, 1'b0);
        // overlap rejected; click held into the write cycle must be dropped
        place_click("overlap", 1'b0, 1'b0, 1'b1, 3'd1, 2'b01, 1'b0);
        rotate = 1'b1;
        tick();
        rotate = 1'b0;
        n_vec++;
        if ({direction, we} !== 2'b10) begin
            n_err++;
            $display("FAIL rotate: dir/we=%b/%b need 1/0", direction, we);
        end
        place_click("click_rotate", 1'b1, 1'b1, 1'b0, 3'd2, 2'b01, 1'b1);
        rotate = 1'b1;
        tick();
        rotate = 1'b0;
        place_click("ship2", 1'b1, 1'b0, 1'b0, 3'd3, 2'b01, 1'b0);
        place_click("ship3_last", 1'b1, 1'b0, 1'b0, 3'd3, 2'b10, 1'b0);
    endtask

    task automatic test_shoot();
        shoot("hit1", 4'd2, 1'b1, 4'd5, 5'd1, 8'd1, 2'b10);
        shoot("miss", 4'd0, 1'b1, 4'd6, 5'd1, 8'd2, 2'b10);
        shoot("repeat_hit", 4'd5, 1'b0, 4'd0, 5'd1, 8'd2, 2'b10);
        shoot("repeat_miss", 4'd6, 1'b0, 4'd0, 5'd1, 8'd2, 2'b10);
        shoot("odd_status", 4'd3, 1'b0, 4'd0, 5'd1, 8'd2, 2'b10);
        for (int i = 2; i <= 12; i++) begin
            shoot($sformatf("hit%0d", i), 4'd2, 1'b1, 4'd5, 5'(i), 8'(i + 1),
                  (i == 12) ? 2'b11 : 2'b10);
        end
        // in DONE, clicks are ignored and counters hold
        shoot("done_click", 4'd2, 1'b0, 4'd0, 5'd12, 8'd13, 2'b11);
    endtask

    task automatic test_rst_mid();
        pulse_start();
        n_vec++;
        if ({play_status, hit_count, shot_count, game_over, ship_idx} !==
            {2'b01, 5'd0, 8'd0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL restart_from_done: play/hit/shot/go/idx=%b/%0d/%0d/%b/%0d need 01/0/0/0/0",
                     play_status, hit_count, shot_count, game_over, ship_idx);
        end
        place_click("pre_rst", 1'b1, 1'b0, 1'b0, 3'd1, 2'b01, 1'b0);
        click = 1'b1; ship_placed = 1'b1;
        tick();
        click = 1'b0;
        n_vec++;
        if (we !== 1'b1) begin
            n_err++;
            $display("FAIL rst_setup: we=%b need 1", we);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (outs() !== 28'd0) begin
            n_err++;
            $display("FAIL async_rst: got %h need 0000000", outs());
        end
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        n_vec++;
        if ({play_status, ship_idx, dimension, we} !== {2'b01, 3'd0, 3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL restart: play/idx/dim/we=%b/%0d/%0d/%b need 01/0/4/0",
                     play_status, ship_idx, dimension, we);
        end
    endtask

    initial begin
        test_reset();
        test_place();
        test_shoot();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
